spi_note_tx: RTL and testbench
==============================

# spi_note_tx

SPI master that serialises one 24-bit note packet (16-bit tuning word, then 8-bit volume) onto the `chipSelect`/`sck`/`sdi` wires, in exactly the format the FPGA note receiver accepts. It lets the design, or a bench, stand in for the microcontroller as the packet source. Examples include self-test, loopback, and driving a second synthesiser board. Packets are accepted through a valid/ready handshake and shifted out MSB first, with a programmable SCK rate.

## Interface
- `CLK_DIV`, default 4: number of `clk` cycles per SCK half-period (D); legal range 2..255.
- `clk`  in  1  system clock (40 MHz); the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `tuneWord`  in  16  phase-increment word to send; sampled only on acceptance.
- `volume`  in  8  unsigned volume to send; sampled only on acceptance.
- `inValid`  in  1  a packet is presented on `tuneWord`/`volume`.
- `inReady`  out  1  block is idle and will accept a packet this cycle.
- `chipSelect`  out  1  active-high frame enable; registered.
- `sck`  out  1  serial clock; idles low, receiver samples on rising edge; registered.
- `sdi`  out  1  serial data, MSB first; registered.
- `busy`  out  1  a packet is in flight (not IDLE).
- `done`  out  1  one-cycle pulse when a packet has fully completed.

## Operation
- Shift register, 24 bits, loaded with {tuneWord, volume} on acceptance (`inValid && inReady`).
- Divider counter counts 0..D-1; bit counter 0..23, 5 bits.
- States and transitions:
  - IDLE: `inReady`=1. On acceptance, go to LEAD.
  - LEAD: `chipSelect`=1, `sck`=0, `sdi`=bit 23, for D cycles. Then go to HI.
  - HI: `sck`=1 for D cycles. After the D cycles, if bit count = 23 go to TRAIL, else go to LO.
  - LO: `sck`=0 for D cycles. `sdi` advances to the next bit on the first LO cycle; bit count increments. Then go to HI.
  - TRAIL: `sck`=0, `chipSelect`=1, `sdi`=0, for D cycles. Then go to GAP.
  - GAP: `chipSelect`=0 for D cycles, so the receiver clears its bit count. Then go to IDLE with `done`=1 for that first IDLE cycle.
- SCK behaviour:
  - Exactly 24 rising edges per frame.
  - `sdi` is constant from D cycles before each rising edge until D cycles after it.
  - `sck` never rises while `chipSelect`=0.
- `inReady` = (state == IDLE), with no registered lag.
  - A packet may be accepted in the same cycle `done` is high, which gives back-to-back frames.
- `inValid` while not ready is ignored. The inputs are not sampled, so the source must hold them until accepted.
- `busy` = (state != IDLE).
- Reset value of every output: `chipSelect`=0, `sck`=0, `sdi`=0, `busy`=0, `done`=0. The state is IDLE, so `inReady`=1 in the first cycle after reset is released.
- Reset mid-frame:
  - Abort immediately; the next cycle all wire outputs are 0 and `done` is never pulsed.
  - The partial frame is discarded, and the receiver's chip-select gating drops it.
- Widths: divider counter is 8 bits; all counters wrap only under state control, never free-run.

## Timing
- Acceptance at cycle 0 leads to `chipSelect` rising in cycle 1 (registered).
- Bit k (k=0 is the MSB of `tuneWord`):
  - the rising edge of `sck` is at cycle 1 + D + 2kD;
  - the falling edge is at cycle 1 + 2D + 2kD.
- `chipSelect` high for 49D cycles, falling at cycle 1+49D.
- `done`/`inReady` at cycle 1+50D; frame period 50D+1 cycles with back-to-back acceptance.
- D=4 at 40 MHz:
  - SCK is 5 MHz;
  - `chipSelect` is high over cycles 1..196;
  - `done` is at cycle 201.
- Minimum `chipSelect`-low gap between frames: D+1 cycles (GAP plus the IDLE/accept cycle).

## Test plan
- D=4; reset, then send tuneWord=0xA5C3, volume=0x7F. Required response:
  - the bench samples `sdi` on each `sck` rising edge and gets 0xA5C37F;
  - exactly 24 rising edges;
  - `chipSelect` high for cycles 1..196;
  - `done` is a single pulse at 201.
- Back-to-back: hold `inValid`=1 with 0x1234/0x56, then 0xFFFF/0x00. Required response:
  - second acceptance in the `done` cycle;
  - `chipSelect` low for exactly 5 cycles between frames;
  - both words decoded correctly.
- Busy-ignore: after acceptance of 0x0001/0x02, change inputs to 0xBEEF/0xAA with `inValid`=1 mid-frame. Required response: 0x000102 is transmitted, `inReady`=0 throughout the frame, and 0xBEEFAA follows as the next frame.
- Reset mid-frame: assert `reset` for 1 cycle after the 10th rising edge. Required response:
  - next cycle `chipSelect`=`sck`=`sdi`=0;
  - no `done`;
  - `inReady`=1 after release;
  - a following packet 0x4321/0x10 is sent correctly.
- D=2 corner: send 0x0000/0x00, then 0xFFFF/0xFF. Required response:
  - `sdi` stable for ≥2 cycles on both sides of every rising edge;
  - 24 edges per frame;
  - `done` at cycle 101 after each acceptance.
- D=255: single frame 0x8000/0x01. Required response: `chipSelect` high for 12495 cycles, first rising edge at cycle 256, `done` at cycle 12751.

Source files
------------

// File: rtl/spi_note_tx_if.sv
// Packet handshake plus SPI wire bundle between a note-packet source and spi_note_tx.
interface spi_note_if;
    logic [15:0] tuneWord;
    logic [7:0]  volume;
    logic        inValid;
    logic        inReady;
    logic        chipSelect;
    logic        sck;
    logic        sdi;
    logic        busy;
    logic        done;

    modport master (
        output tuneWord, volume, inValid,
        input  inReady, chipSelect, sck, sdi, busy, done
    );

    modport slave (
        input  tuneWord, volume, inValid,
        output inReady, chipSelect, sck, sdi, busy, done
    );
endinterface

// File: rtl/spi_note_tx.sv
// SPI master: shifts one {tuneWord, volume} 24-bit packet out MSB first,
// SCK half-period of CLK_DIV clk cycles, framed by an active-high chipSelect.
module spi_note_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic      clk,
    input  logic      reset,
    spi_note_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LEAD, HI, LO, TRAIL, GAP} state_t;

    localparam logic [7:0] DLAST = 8'(CLK_DIV - 1);

    state_t      state, state_n;
    logic [7:0]  div, div_n;
    logic [4:0]  bitcnt, bitcnt_n;
    logic [23:0] shreg, shreg_n;
    logic        cs_q, cs_n;
    logic        sck_q, sck_n;
    logic        done_q, done_n;
    logic        last;
    logic        accept;

    assign last   = (div == DLAST);
    assign accept = bus.inValid && (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            div    <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            cs_q   <= 1'b0;
            sck_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            div    <= div_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
            cs_q   <= cs_n;
            sck_q  <= sck_n;
            done_q <= done_n;
        end
    end

    // Output flops are loaded on state entry, so each wire changes in the
    // same cycle the new state becomes visible.
    always_comb begin
        state_n  = state;
        div_n    = last ? 8'd0 : div + 8'd1;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        cs_n     = cs_q;
        sck_n    = sck_q;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                div_n = 8'd0;
                if (accept) begin
                    state_n  = LEAD;
                    shreg_n  = {bus.tuneWord, bus.volume};
                    bitcnt_n = 5'd0;
                    cs_n     = 1'b1;
                    sck_n    = 1'b0;
                end
            end
            LEAD: if (last) begin
                state_n = HI;
                sck_n   = 1'b1;
            end
            HI: if (last) begin
                sck_n   = 1'b0;
                // The shift after the final bit leaves zeros, so sdi drops in TRAIL.
                shreg_n = {shreg[22:0], 1'b0};
                if (bitcnt == 5'd23) begin
                    state_n = TRAIL;
                end else begin
                    state_n  = LO;
                    bitcnt_n = bitcnt + 5'd1;
                end
            end
            LO: if (last) begin
                state_n = HI;
                sck_n   = 1'b1;
            end
            TRAIL: if (last) begin
                state_n = GAP;
                cs_n    = 1'b0;
            end
            GAP: if (last) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.inReady    = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.chipSelect = cs_q;
    assign bus.sck        = sck_q;
    assign bus.sdi        = shreg[23];
    assign bus.done       = done_q;
endmodule

// File: tb/tb_spi_note_tx.sv
// Bench for spi_note_tx at D=4, D=2 and D=255; every frame is compared
// cycle by cycle against the waveform the SPI timing rules predict.
module tb_spi_note_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_all = 1'b1;
    logic        rst_one = 1'b0;
    int          sel = 0;
    logic [15:0] tw = '0;
    logic [7:0]  vl = '0;
    logic        iv = 1'b0;

    int checks = 0;
    int errors = 0;

    spi_note_if if4 ();
    spi_note_if if2 ();
    spi_note_if if255 ();

    assign if4.tuneWord   = tw;
    assign if4.volume     = vl;
    assign if4.inValid    = iv && (sel == 0);
    assign if2.tuneWord   = tw;
    assign if2.volume     = vl;
    assign if2.inValid    = iv && (sel == 1);
    assign if255.tuneWord = tw;
    assign if255.volume   = vl;
    assign if255.inValid  = iv && (sel == 2);

    spi_note_tx #(.CLK_DIV(4))   u_d4   (.clk(clk), .reset(rst_all || (rst_one && sel == 0)), .bus(if4));
    spi_note_tx #(.CLK_DIV(2))   u_d2   (.clk(clk), .reset(rst_all || (rst_one && sel == 1)), .bus(if2));
    spi_note_tx #(.CLK_DIV(255)) u_d255 (.clk(clk), .reset(rst_all || (rst_one && sel == 2)), .bus(if255));

    logic o_rdy, o_cs, o_sck, o_sdi, o_busy, o_done;
    always_comb begin
        o_rdy = if4.inReady; o_cs = if4.chipSelect; o_sck = if4.sck;
        o_sdi = if4.sdi; o_busy = if4.busy; o_done = if4.done;
        if (sel == 1) begin
            o_rdy = if2.inReady; o_cs = if2.chipSelect; o_sck = if2.sck;
            o_sdi = if2.sdi; o_busy = if2.busy; o_done = if2.done;
        end else if (sel == 2) begin
            o_rdy = if255.inReady; o_cs = if255.chipSelect; o_sck = if255.sck;
            o_sdi = if255.sdi; o_busy = if255.busy; o_done = if255.done;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge; presents pkt and runs the frame to its done cycle
    // (returns at that cycle's negedge). chain keeps inValid high with nxt.
    task automatic xfer(input int d, input logic [23:0] pkt, input bit chain,
                        input logic [23:0] nxt, input string tag);
        logic [23:0] word = '0;
        int edges = 0, first = 0, wave_err = 0, hs_err = 0, cs_hi = 0, cs_lo = 0;
        logic prev = 1'b0;
        logic e_cs, e_sck, e_sdi, fin;
        int bit_i;
        {tw, vl} = pkt;
        iv = 1'b1;
        chk({tag, " accept"}, 32'(o_rdy), 32'd1);
        @(posedge clk); @(negedge clk);
        if (chain) {tw, vl} = nxt;
        else iv = 1'b0;
        for (int c = 1; c <= 1 + 50 * d; c++) begin
            if (c > 1) begin @(posedge clk); @(negedge clk); end
            fin   = (c == 1 + 50 * d);
            bit_i = 23 - (c - 1) / (2 * d);
            e_cs  = (c <= 49 * d);
            e_sck = (c <= 48 * d) && (((c - 1) % (2 * d)) >= d);
            e_sdi = (c <= 48 * d) ? pkt[bit_i] : 1'b0;
            if (o_cs !== e_cs || o_sck !== e_sck || (c <= 49 * d && o_sdi !== e_sdi)) wave_err++;
            if (o_rdy !== fin || o_done !== fin || o_busy !== !fin) hs_err++;
            if (o_sck && !prev) begin
                edges++;
                word = {word[22:0], o_sdi};
                if (edges == 1) first = c;
            end
            prev = o_sck;
            if (o_cs) cs_hi++; else cs_lo++;
        end
        chk({tag, " word"}, 32'(word), 32'(pkt));
        chk({tag, " edges"}, 32'(edges), 32'd24);
        chk({tag, " first edge"}, 32'(first), 32'(1 + d));
        chk({tag, " cs high cycles"}, 32'(cs_hi), 32'(49 * d));
        chk({tag, " cs low to done"}, 32'(cs_lo), 32'(d + 1));
        chk({tag, " waveform errs"}, 32'(wave_err), 32'd0);
        chk({tag, " handshake errs"}, 32'(hs_err), 32'd0);
    endtask

    task automatic settle(input string tag);
        @(posedge clk); @(negedge clk);
        chk({tag, " done single"}, 32'({o_done, o_rdy, o_cs}), 32'b010);
    endtask

    initial begin
        logic [23:0] r, r2;
        int edges;
        logic prev;
        // Reset state on all three instances
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            chk("reset outs", 32'({o_cs, o_sck, o_sdi, o_busy, o_done}), 32'd0);
        end
        rst_all = 1'b0;
        @(posedge clk); @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            chk("ready after reset", 32'({o_rdy, o_busy}), 32'b10);
        end
        sel = 0;

        xfer(4, 24'hA5C37F, 1'b0, 24'h0, "d4 basic");
        settle("d4 basic");
        xfer(4, 24'h123456, 1'b1, 24'hFFFF00, "b2b first");
        xfer(4, 24'hFFFF00, 1'b0, 24'h0, "b2b second");
        settle("b2b");
        xfer(4, 24'h000102, 1'b1, 24'hBEEFAA, "busy ignore");
        xfer(4, 24'hBEEFAA, 1'b0, 24'h0, "busy follow");
        settle("busy");

        r = 24'($urandom);
        for (int i = 0; i < 3; i++) begin
            r2 = 24'($urandom);
            xfer(4, r, 1'b1, r2, "d4 random");
            r = r2;
        end
        xfer(4, r, 1'b0, 24'h0, "d4 random last");
        settle("d4 random");

        // Reset after the 10th rising edge
        {tw, vl} = 24'($urandom);
        iv = 1'b1;
        chk("midrst accept", 32'(o_rdy), 32'd1);
        @(posedge clk); @(negedge clk);
        iv = 1'b0;
        edges = 0;
        prev = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (o_sck && !prev) edges++;
            prev = o_sck;
            if (edges == 10) break;
            @(posedge clk); @(negedge clk);
        end
        chk("midrst 10 edges", 32'(edges), 32'd10);
        rst_one = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("midrst wires", 32'({o_cs, o_sck, o_sdi, o_done, o_busy}), 32'd0);
        rst_one = 1'b0;
        edges = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); @(negedge clk);
            if (o_done !== 1'b0 || o_rdy !== 1'b1 || o_cs !== 1'b0) edges++;
        end
        chk("midrst idle no done", 32'(edges), 32'd0);
        xfer(4, 24'h432110, 1'b0, 24'h0, "after reset");
        settle("after reset");

        sel = 1;
        #1;
        xfer(2, 24'h000000, 1'b1, 24'hFFFFFF, "d2 zeros");
        xfer(2, 24'hFFFFFF, 1'b0, 24'h0, "d2 ones");
        settle("d2");
        xfer(2, 24'($urandom), 1'b0, 24'h0, "d2 random");
        settle("d2 random");

        sel = 2;
        #1;
        xfer(255, 24'h800001, 1'b0, 24'h0, "d255");
        settle("d255");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
